// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU-drive and response signals between a requester, the issue controller and the shared ALU.
// The slave modport is the controller's view; the master modport is the requester/ALU side.
interface alu_issue_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_funct3;
    logic       req_funct7b5;
    logic [3:0] req_a;
    logic [3:0] req_b;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_sel;
    logic [3:0] alu_out;
    logic       alu_carry;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_carry;
    logic       rsp_err;

    modport slave (
        input  req_valid, req_funct3, req_funct7b5, req_a, req_b, alu_out, alu_carry, rsp_ready,
        output req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_carry, rsp_err
    );

    modport master (
        output req_valid, req_funct3, req_funct7b5, req_a, req_b, alu_out, alu_carry, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_carry, rsp_err
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the shared 4-bit ALU: decodes RISC-V OP requests, sequences
// single-pass and multi-pass (shift) operations and returns result/carry/error.
module alu_issue_ctrl #(
    parameter int SHAMT_W      = 2,
    parameter bit ISOLATE_IDLE = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    alu_issue_ctrl_if.slave bus
);
    localparam int DATA_W = 4;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    typedef enum logic [2:0] {K_ARITH, K_LOGIC, K_SLT, K_SLTU, K_SHIFT, K_ILLEGAL} kind_t;
    typedef struct packed {
        kind_t      kind;
        logic [2:0] sel;
    } dec_t;

    function automatic dec_t decode(input logic [2:0] funct3, input logic funct7b5);
        dec_t d;
        d.kind = K_ILLEGAL;
        d.sel  = 3'b000;
        case ({funct3, funct7b5})
            4'b000_0: begin d.kind = K_ARITH; d.sel = 3'b000; end
            4'b000_1: begin d.kind = K_ARITH; d.sel = 3'b001; end
            4'b111_0: begin d.kind = K_LOGIC; d.sel = 3'b010; end
            4'b110_0: begin d.kind = K_LOGIC; d.sel = 3'b011; end
            4'b100_0: begin d.kind = K_LOGIC; d.sel = 3'b100; end
            4'b001_0: begin d.kind = K_SHIFT; d.sel = 3'b110; end
            4'b101_0: begin d.kind = K_SHIFT; d.sel = 3'b111; end
            4'b010_0: begin d.kind = K_SLT;   d.sel = 3'b001; end
            4'b011_0: begin d.kind = K_SLTU;  d.sel = 3'b001; end
            default: ;
        endcase
        return d;
    endfunction

    state_t              state;
    logic                ready;
    logic [DATA_W-1:0]   alu_a_q, alu_b_q;
    logic [2:0]          alu_sel_q;
    logic                rsp_valid_q, rsp_carry_q, rsp_err_q;
    logic [DATA_W-1:0]   rsp_data_q;
    kind_t               kind_q;
    logic                a_sign, b_sign;
    logic [SHAMT_W-1:0]  shamt_q, pass_cnt;

    dec_t                dec;
    logic                accept;
    logic [SHAMT_W-1:0]  cnt_nxt;
    logic                slt_lt;
    logic                exec_done;
    logic [DATA_W-1:0]   exec_data;
    logic                exec_carry;

    assign dec     = decode(bus.req_funct3, bus.req_funct7b5);
    assign accept  = bus.req_valid && ready;
    assign cnt_nxt = pass_cnt + 1'b1;
    // Signed compare from the subtract: differing signs decide directly, else the difference sign.
    assign slt_lt  = (a_sign != b_sign) ? a_sign : bus.alu_out[DATA_W-1];

    always_comb begin
        exec_done  = (kind_q != K_SHIFT) || (cnt_nxt == shamt_q);
        exec_data  = bus.alu_out;
        exec_carry = bus.alu_carry;
        case (kind_q)
            K_LOGIC: exec_carry = 1'b0;
            K_SLT:   exec_data  = {{(DATA_W-1){1'b0}}, slt_lt};
            K_SLTU:  exec_data  = {{(DATA_W-1){1'b0}}, bus.alu_carry};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ready       <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            kind_q      <= K_ARITH;
            a_sign      <= 1'b0;
            b_sign      <= 1'b0;
            shamt_q     <= '0;
            pass_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ready <= !accept;
                    if (accept) begin
                        kind_q   <= dec.kind;
                        a_sign   <= bus.req_a[DATA_W-1];
                        b_sign   <= bus.req_b[DATA_W-1];
                        shamt_q  <= bus.req_b[SHAMT_W-1:0];
                        pass_cnt <= '0;
                        if (dec.kind == K_ILLEGAL) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= '0;
                            rsp_carry_q <= 1'b0;
                            rsp_err_q   <= 1'b1;
                        end else if (dec.kind == K_SHIFT && bus.req_b[SHAMT_W-1:0] == '0) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= bus.req_a;
                            rsp_carry_q <= 1'b0;
                            rsp_err_q   <= 1'b0;
                        end else begin
                            state     <= EXEC;
                            alu_a_q   <= bus.req_a;
                            alu_b_q   <= bus.req_b;
                            alu_sel_q <= dec.sel;
                        end
                    end
                end
                EXEC: begin
                    pass_cnt <= cnt_nxt;
                    if (exec_done) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= exec_data;
                        rsp_carry_q <= exec_carry;
                        rsp_err_q   <= 1'b0;
                        if (!ISOLATE_IDLE) begin
                            alu_a_q   <= '0;
                            alu_b_q   <= '0;
                            alu_sel_q <= '0;
                        end
                    end else begin
                        // Feed the partial shift result back for the next single-bit pass.
                        alu_a_q <= bus.alu_out;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                        ready       <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_sel   = alu_sel_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_carry = rsp_carry_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural model of the shared 4-bit ALU.
module tb_alu_issue_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   lat;

    alu_issue_ctrl_if bus();

    alu_issue_ctrl #(.SHAMT_W(2), .ISOLATE_IDLE(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Shared ALU: SUB carry is borrow, shifts move one bit and report the bit shifted out.
    always_comb begin
        bus.alu_out   = 4'h0;
        bus.alu_carry = 1'b0;
        case (bus.alu_sel)
            3'b000: {bus.alu_carry, bus.alu_out} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            3'b001: begin bus.alu_out = bus.alu_a - bus.alu_b; bus.alu_carry = (bus.alu_a < bus.alu_b); end
            3'b010: bus.alu_out = bus.alu_a & bus.alu_b;
            3'b011: bus.alu_out = bus.alu_a | bus.alu_b;
            3'b100: bus.alu_out = bus.alu_a ^ bus.alu_b;
            3'b110: begin bus.alu_out = {bus.alu_a[2:0], 1'b0}; bus.alu_carry = bus.alu_a[3]; end
            3'b111: begin bus.alu_out = {1'b0, bus.alu_a[3:1]}; bus.alu_carry = bus.alu_a[0]; end
            default: ;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic f7, input logic [3:0] a, input logic [3:0] b);
        bus.req_funct3   = f3;
        bus.req_funct7b5 = f7;
        bus.req_a        = a;
        bus.req_b        = b;
        bus.req_valid    = 1'b1;
        step();
        bus.req_valid    = 1'b0;
    endtask

    task automatic check_rsp(input string tag, input int start, input int exp_lat,
                             input logic [3:0] data, input logic carry, input logic err);
        lat = start;
        while (!bus.rsp_valid && lat < start + 12) begin
            step();
            lat++;
        end
        chk({tag, "_lat"},   4'(lat),           4'(exp_lat));
        chk({tag, "_data"},  bus.rsp_data,      data);
        chk({tag, "_carry"}, 4'(bus.rsp_carry), 4'(carry));
        chk({tag, "_err"},   4'(bus.rsp_err),   4'(err));
    endtask

    task automatic handshake(input string tag);
        step();
        chk({tag, "_vld_drop"}, 4'(bus.rsp_valid), 4'd0);
        chk({tag, "_ready"},    4'(bus.req_ready), 4'd1);
    endtask

    initial begin
        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_funct3   = 3'b000;
        bus.req_funct7b5 = 1'b0;
        bus.req_a        = 4'h0;
        bus.req_b        = 4'h0;
        bus.rsp_ready    = 1'b1;
        step();
        step();
        chk("rst_ready", 4'(bus.req_ready), 4'd0);
        chk("rst_vld",   4'(bus.rsp_valid), 4'd0);
        chk("rst_alu_a", bus.alu_a,         4'd0);
        chk("rst_sel",   4'(bus.alu_sel),   4'd0);
        chk("rst_data",  bus.rsp_data,      4'd0);
        rst = 1'b0;
        step();
        chk("post_rst_ready", 4'(bus.req_ready), 4'd1);

        issue(3'b000, 1'b0, 4'b1001, 4'b1000);
        chk("add_sel", 4'(bus.alu_sel), 4'b0000);
        chk("add_ready_low", 4'(bus.req_ready), 4'd0);
        check_rsp("add", 1, 2, 4'b0001, 1'b1, 1'b0);
        handshake("add");

        issue(3'b010, 1'b0, 4'b1110, 4'b0001);
        check_rsp("slt", 1, 2, 4'b0001, 1'b0, 1'b0);
        handshake("slt");

        issue(3'b011, 1'b0, 4'b1110, 4'b0001);
        check_rsp("sltu", 1, 2, 4'b0000, 1'b0, 1'b0);
        handshake("sltu");

        issue(3'b000, 1'b1, 4'b0010, 4'b0101);
        check_rsp("sub", 1, 2, 4'b1101, 1'b1, 1'b0);
        handshake("sub");

        issue(3'b101, 1'b1, 4'b0111, 4'b0110);
        check_rsp("illegal", 1, 1, 4'b0000, 1'b0, 1'b1);
        chk("illegal_alu_a", bus.alu_a,       4'b0010);
        chk("illegal_alu_b", bus.alu_b,       4'b0101);
        chk("illegal_sel",   4'(bus.alu_sel), 4'b0001);
        handshake("illegal");

        issue(3'b001, 1'b0, 4'b1010, 4'b0100);
        check_rsp("sll0", 1, 1, 4'b1010, 1'b0, 1'b0);
        chk("sll0_alu_a", bus.alu_a, 4'b0010);
        handshake("sll0");

        issue(3'b001, 1'b0, 4'b0011, 4'b0010);
        chk("sll_sel",    4'(bus.alu_sel), 4'b0110);
        chk("sll_a_pass1", bus.alu_a,      4'b0011);
        step();
        chk("sll_a_pass2", bus.alu_a,      4'b0110);
        check_rsp("sll", 2, 3, 4'b1100, 1'b0, 1'b0);
        handshake("sll");

        issue(3'b101, 1'b0, 4'b1101, 4'b0011);
        chk("srl_sel", 4'(bus.alu_sel), 4'b0111);
        check_rsp("srl", 1, 4, 4'b0001, 1'b1, 1'b0);
        handshake("srl");

        bus.rsp_ready = 1'b0;
        issue(3'b100, 1'b0, 4'b0101, 4'b0011);
        check_rsp("xor_bp", 1, 2, 4'b0110, 1'b0, 1'b0);
        bus.req_funct3   = 3'b000;
        bus.req_funct7b5 = 1'b0;
        bus.req_a        = 4'b0001;
        bus.req_b        = 4'b0010;
        bus.req_valid    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_vld",   4'(bus.rsp_valid), 4'd1);
            chk("bp_data",  bus.rsp_data,      4'b0110);
            chk("bp_ready", 4'(bus.req_ready), 4'd0);
        end
        bus.rsp_ready = 1'b1;
        step();
        chk("bp_hs_vld",    4'(bus.rsp_valid), 4'd0);
        chk("bp_bubble_a",  bus.alu_a,         4'b0101);
        chk("bp_bubble_rdy", 4'(bus.req_ready), 4'd1);
        step();
        bus.req_valid = 1'b0;
        chk("bp_accept_a",   bus.alu_a,         4'b0001);
        chk("bp_accept_rdy", 4'(bus.req_ready), 4'd0);
        check_rsp("bp_add", 1, 2, 4'b0011, 1'b0, 1'b0);
        handshake("bp_add");

        issue(3'b101, 1'b0, 4'b1101, 4'b0011);
        step();
        chk("abort_pass2_a", bus.alu_a, 4'b0110);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_alu_a", bus.alu_a,         4'd0);
        chk("abort_sel",   4'(bus.alu_sel),   4'd0);
        chk("abort_ready", 4'(bus.req_ready), 4'd0);
        chk("abort_vld",   4'(bus.rsp_valid), 4'd0);
        step();
        step();
        chk("abort_hold_vld",   4'(bus.rsp_valid), 4'd0);
        chk("abort_hold_ready", 4'(bus.req_ready), 4'd0);
        rst = 1'b0;
        step();
        chk("abort_rel_ready", 4'(bus.req_ready), 4'd1);
        chk("abort_rel_vld",   4'(bus.rsp_valid), 4'd0);
        issue(3'b000, 1'b0, 4'b0011, 4'b0100);
        check_rsp("abort_add", 1, 2, 4'b0111, 1'b0, 1'b0);
        handshake("abort_add");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Requester-side controller for the shared 4-bit ALU.
- Accepts RISC-V-style OP requests (funct3, funct7[5], two 4-bit operands) over a valid/ready handshake and decodes them to the ALU's 3-bit select.
- Drives the ALU's A/B/select inputs and sequences multi-pass operations (shift by N = N single-bit passes) on the one shared ALU.
- Returns result, carry and error over a valid/ready response channel. Holds ALU inputs stable when idle (operand isolation, low power).

Parameters:
SHAMT_W, 2, number of op_b LSBs used as shift amount (0..3)
ISOLATE_IDLE, 1, 1 = hold alu_a/alu_b/alu_sel at last driven value outside EXEC; 0 = drive all zero outside EXEC

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  request valid
req_ready  output  1  controller can accept request
req_funct3  input  3  RISC-V funct3
req_funct7b5  input  1  RISC-V funct7 bit 5
req_a  input  4  operand A (rs1)
req_b  input  4  operand B (rs2 / shamt)
alu_a  output  4  to ALU input A (registered)
alu_b  output  4  to ALU input B (registered)
alu_sel  output  3  to ALU select (registered)
alu_out  input  4  ALU result
alu_carry  input  1  ALU CarryOut
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumed
rsp_data  output  4  result
rsp_carry  output  1  carry/borrow/shifted-out bit
rsp_err  output  1  unsupported operation

Behaviour:
- Reset (async, immediate):
  - state=IDLE; rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_err=0; alu_a=0, alu_b=0, alu_sel=000; pass counter=0.
  - req_ready=0 while rst is high; req_ready=1 from the first cycle after release.
- FSM states IDLE, EXEC, RESP. req_ready=1 only in IDLE.
- IDLE:
  - On req_valid&&req_ready, latch the request and decode it.
  - Legal, non-zero-pass op -> EXEC: alu_a/alu_b/alu_sel loaded at the accept edge.
  - Illegal op or shamt=0 shift -> RESP directly.
- Decode (funct3 / funct7b5 -> alu_sel):
  - 000/0 ADD -> 000; 000/1 SUB -> 001
  - 111/0 AND -> 010; 110/0 OR -> 011; 100/0 XOR -> 100
  - 001/0 SLL -> 110; 101/0 SRL -> 111
  - 010/0 SLT and 011/0 SLTU -> 001 (subtract)
  - Any other combination (including SRA 101/1) is illegal: rsp_err=1, rsp_data=0, rsp_carry=0, no ALU pass, alu_* unchanged.
- EXEC, single-pass ops:
  - One cycle; at the next edge capture the ALU output -> RESP.
  - ADD/SUB/logic: rsp_data=alu_out. rsp_carry=alu_carry for ADD/SUB (SUB carry = borrow); rsp_carry=0 for logic ops.
  - SLTU: rsp_data={000, alu_carry}.
  - SLT: lt = (req_a[3]!=req_b[3]) ? req_a[3] : alu_out[3]; rsp_data={000, lt}. rsp_carry=alu_carry for both.
- EXEC, shifts:
  - n = req_b[SHAMT_W-1:0] passes, one per cycle.
  - Each edge: alu_a <= alu_out, pass counter++, last carry <= alu_carry.
  - After pass n: rsp_data = final alu_out, rsp_carry = bit shifted out on the last pass -> RESP.
  - n=0: RESP directly with rsp_data=req_a, rsp_carry=0.
  - req_b[3:SHAMT_W] ignored.
- Latency, accept edge to rsp_valid high:
  - 1 edge for illegal ops and shamt=0.
  - 2 edges for single-pass ops.
  - n+1 edges for shifts.
- RESP:
  - rsp_valid=1; rsp_data/carry/err stable until rsp_valid&&rsp_ready.
  - Then rsp_valid=0 -> IDLE. No same-cycle new accept: one bubble cycle.
- Outside EXEC: alu_* follow ISOLATE_IDLE (hold or zero). They never toggle while in IDLE or RESP.
- req_valid is ignored outside IDLE; requests are never dropped once accepted.
- Reset mid-EXEC or mid-RESP aborts the operation; no response is produced.

Test Plan:
- ADD a=1001 b=1000 f3=000 f7b5=0 -> alu_sel=000 for 1 cycle; rsp_valid 2 edges after accept; rsp_data=0001, rsp_carry=1, rsp_err=0.
- SLT a=1110 b=0001 f3=010 -> rsp_data=0001; SLTU same operands f3=011 -> rsp_data=0000; SUB a=0010 b=0101 -> rsp_data=1101, rsp_carry=1.
- SLL a=0011 b=0010 -> 2 EXEC cycles, alu_sel=110, alu_a 0011->0110 -> rsp_data=1100, rsp_carry=0; SRL a=1101 b=0011 -> rsp_data=0001, rsp_carry=1, latency 4.
- Illegal f3=101 f7b5=1 -> rsp_err=1, rsp_data=0 after 1 edge, alu_* unchanged; shamt=0 SLL a=1010 -> rsp_data=1010, rsp_carry=0 after 1 edge.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/data/carry stable, req_ready=0, second req_valid held high is accepted only after the handshake plus one bubble cycle.
- rst asserted during pass 2 of a 3-pass SRL -> outputs reset immediately, req_ready=0 during reset, no rsp_valid; after release req_ready=1 and a new ADD completes normally.
